// File: rtl/alu_result_packer_if.sv
// Byte-wide valid/ready link from the result packer into the TX FIFO write side.
// A byte moves on a rising edge where TX_VALID and TX_READY are both high; while TX_VALID is high and TX_READY is low, TX_DATA and TX_VALID hold.
interface alu_result_packer_if;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);
endinterface

// File: rtl/alu_result_packer.sv
// Captures the result of whichever ALU sub-unit fired and streams it LSB-first
// as bytes to the TX FIFO. The state sequence is IDLE -> CAPTURE -> SEND.
module alu_result_packer #(
    parameter int OUT_WIDTH   = 16,
    parameter int ARITH_WIDTH = 16,
    parameter int LOGIC_WIDTH = 8,
    parameter int CMP_WIDTH   = 8,
    parameter int SHIFT_WIDTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ARITH_WIDTH-1:0] Arith_OUT,
    input  logic                   Arith_Flag,
    input  logic [LOGIC_WIDTH-1:0] Logic_OUT,
    input  logic                   Logic_Flag,
    input  logic [CMP_WIDTH-1:0]   CMP_OUT,
    input  logic                   CMP_Flag,
    input  logic [SHIFT_WIDTH-1:0] SHIFT_OUT,
    input  logic                   SHIFT_Flag,
    output logic [OUT_WIDTH-1:0]   RES_OUT,
    output logic                   RES_VALID,
    alu_result_packer_if.master    tx,
    output logic                   BUSY,
    output logic                   DROP,
    output logic                   MULTI_ERR,
    output logic [1:0]             STATE_DBG
);
    localparam int NBYTES = OUT_WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_SEND = 2'd2} state_e;
    typedef enum logic [1:0] {U_ARITH = 2'd0, U_LOGIC = 2'd1, U_CMP = 2'd2, U_SHIFT = 2'd3} unit_e;

    state_e                 state_q, state_d;
    unit_e                  sel_q, sel_d;
    logic [OUT_WIDTH-1:0]   res_q, res_d;
    logic [OUT_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   res_valid_q, res_valid_d;
    logic                   drop_q, drop_d;
    logic                   multi_q, multi_d;
    logic                   any_flag;
    logic [2:0]             nflags;
    logic [OUT_WIDTH-1:0]   sel_word;

    assign any_flag = Arith_Flag | Logic_Flag | CMP_Flag | SHIFT_Flag;
    assign nflags   = {2'b00, Arith_Flag} + {2'b00, Logic_Flag}
                    + {2'b00, CMP_Flag} + {2'b00, SHIFT_Flag};

    // The unit was chosen a cycle earlier; its registered output is valid now.
    always_comb begin
        sel_word = '0;
        case (sel_q)
            U_ARITH: sel_word[ARITH_WIDTH-1:0] = Arith_OUT;
            U_LOGIC: sel_word[LOGIC_WIDTH-1:0] = Logic_OUT;
            U_CMP:   sel_word[CMP_WIDTH-1:0]   = CMP_OUT;
            default: sel_word[SHIFT_WIDTH-1:0] = SHIFT_OUT;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        res_d       = res_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        res_valid_d = 1'b0;
        drop_d      = 1'b0;
        multi_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_flag) begin
                    state_d = S_CAPTURE;
                    multi_d = (nflags > 3'd1);
                    if (Arith_Flag)      sel_d = U_ARITH;
                    else if (Logic_Flag) sel_d = U_LOGIC;
                    else if (CMP_Flag)   sel_d = U_CMP;
                    else                 sel_d = U_SHIFT;
                end
            end
            S_CAPTURE: begin
                drop_d      = any_flag;
                res_d       = sel_word;
                shreg_d     = sel_word;
                cnt_d       = '0;
                res_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                drop_d = any_flag;
                if (tx.TX_READY) begin
                    shreg_d = shreg_q >> 8;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(NBYTES - 1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            sel_q       <= U_ARITH;
            res_q       <= '0;
            shreg_q     <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            res_q       <= res_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            drop_q      <= drop_d;
            multi_q     <= multi_d;
        end
    end

    assign RES_OUT     = res_q;
    assign RES_VALID   = res_valid_q;
    assign tx.TX_DATA  = shreg_q[7:0];
    assign tx.TX_VALID = (state_q == S_SEND);
    assign BUSY        = (state_q != S_IDLE);
    assign DROP        = drop_q;
    assign MULTI_ERR   = multi_q;
    assign STATE_DBG   = state_q;
endmodule

// File: tb/tb_alu_result_packer.sv
// Directed bench for alu_result_packer: hand-computed vectors for each unit,
// backpressure, simultaneous flags, flag-while-busy and reset mid-transfer.
module tb_alu_result_packer;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] Arith_OUT = '0;
    logic        Arith_Flag = 1'b0;
    logic [7:0]  Logic_OUT = '0;
    logic        Logic_Flag = 1'b0;
    logic [7:0]  CMP_OUT = '0;
    logic        CMP_Flag = 1'b0;
    logic [7:0]  SHIFT_OUT = '0;
    logic        SHIFT_Flag = 1'b0;
    logic [15:0] RES_OUT;
    logic        RES_VALID, BUSY, DROP, MULTI_ERR;
    logic [1:0]  STATE_DBG;

    int n_cmp = 0;
    int n_bad = 0;

    alu_result_packer_if tx_if ();

    alu_result_packer dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Arith_Flag (Arith_Flag),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .CMP_OUT    (CMP_OUT),
        .CMP_Flag   (CMP_Flag),
        .SHIFT_OUT  (SHIFT_OUT),
        .SHIFT_Flag (SHIFT_Flag),
        .RES_OUT    (RES_OUT),
        .RES_VALID  (RES_VALID),
        .tx         (tx_if.master),
        .BUSY       (BUSY),
        .DROP       (DROP),
        .MULTI_ERR  (MULTI_ERR),
        .STATE_DBG  (STATE_DBG)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs and outputs are both handled on the falling edge, away from the active edge.
    task automatic step();
        @(negedge CLK);
    endtask

    // unit: 0 arith, 1 logic, 2 cmp, 3 shift
    task automatic set_flag(input int unit, input logic v);
        case (unit)
            0: Arith_Flag = v;
            1: Logic_Flag = v;
            2: CMP_Flag   = v;
            default: SHIFT_Flag = v;
        endcase
    endtask

    task automatic set_out(input int unit, input logic [15:0] val);
        case (unit)
            0: Arith_OUT = val;
            1: Logic_OUT = val[7:0];
            2: CMP_OUT   = val[7:0];
            default: SHIFT_OUT = val[7:0];
        endcase
    endtask

    // Full result with TX_READY held high; exp_res, b0 and b1 are hand-computed.
    task automatic run_result(input string tag, input int unit, input logic [15:0] val,
                              input logic [15:0] exp_res, input logic [7:0] b0,
                              input logic [7:0] b1);
        int busy_cycles;
        busy_cycles = 0;
        tx_if.TX_READY = 1'b1;
        set_flag(unit, 1'b1);
        step();
        set_flag(unit, 1'b0);
        set_out(unit, val);
        if (BUSY) busy_cycles++;
        check({tag, "_cap_tx_valid"}, 32'(tx_if.TX_VALID), 32'd0);
        check({tag, "_cap_res_valid"}, 32'(RES_VALID), 32'd0);
        step();
        if (BUSY) busy_cycles++;
        check({tag, "_res_out"}, 32'(RES_OUT), 32'(exp_res));
        check({tag, "_res_valid"}, 32'(RES_VALID), 32'd1);
        check({tag, "_byte0_valid"}, 32'(tx_if.TX_VALID), 32'd1);
        check({tag, "_byte0"}, 32'(tx_if.TX_DATA), 32'(b0));
        step();
        if (BUSY) busy_cycles++;
        check({tag, "_res_valid_pulse"}, 32'(RES_VALID), 32'd0);
        check({tag, "_byte1_valid"}, 32'(tx_if.TX_VALID), 32'd1);
        check({tag, "_byte1"}, 32'(tx_if.TX_DATA), 32'(b1));
        step();
        if (BUSY) busy_cycles++;
        check({tag, "_done_tx_valid"}, 32'(tx_if.TX_VALID), 32'd0);
        check({tag, "_res_hold"}, 32'(RES_OUT), 32'(exp_res));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd3);
    endtask

    initial begin
        tx_if.TX_READY = 1'b1;
        step();
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_tx_valid", 32'(tx_if.TX_VALID), 32'd0);
        check("reset_res_out", 32'(RES_OUT), 32'd0);
        check("reset_tx_data", 32'(tx_if.TX_DATA), 32'd0);
        RST = 1'b1;
        step();

        run_result("arith", 0, 16'hBEEF, 16'hBEEF, 8'hEF, 8'hBE);
        run_result("cmp", 2, 16'h0003, 16'h0003, 8'h03, 8'h00);
        run_result("shift", 3, 16'h0081, 16'h0081, 8'h81, 8'h00);

        // Backpressure: TX_READY low for 4 SEND cycles
        tx_if.TX_READY = 1'b0;
        Logic_Flag = 1'b1;
        step();
        Logic_Flag = 1'b0;
        Logic_OUT = 8'h5A;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_hold_valid_%0d", i), 32'(tx_if.TX_VALID), 32'd1);
            check($sformatf("bp_hold_data_%0d", i), 32'(tx_if.TX_DATA), 32'h5A);
            if (i < 3) step();
        end
        check("bp_res_out", 32'(RES_OUT), 32'h005A);
        tx_if.TX_READY = 1'b1;
        step();
        check("bp_byte1", 32'(tx_if.TX_DATA), 32'h00);
        check("bp_byte1_valid", 32'(tx_if.TX_VALID), 32'd1);
        step();
        check("bp_done_busy", 32'(BUSY), 32'd0);

        // Simultaneous flags: arith wins, MULTI_ERR pulses once
        Arith_Flag = 1'b1;
        SHIFT_Flag = 1'b1;
        step();
        Arith_Flag = 1'b0;
        SHIFT_Flag = 1'b0;
        Arith_OUT = 16'h1234;
        SHIFT_OUT = 8'h77;
        check("multi_err_pulse", 32'(MULTI_ERR), 32'd1);
        step();
        check("multi_err_clear", 32'(MULTI_ERR), 32'd0);
        check("multi_res_out", 32'(RES_OUT), 32'h1234);
        check("multi_byte0", 32'(tx_if.TX_DATA), 32'h34);
        step();
        check("multi_byte1", 32'(tx_if.TX_DATA), 32'h12);
        check("multi_no_drop", 32'(DROP), 32'd0);
        step();
        check("multi_done_busy", 32'(BUSY), 32'd0);

        // Flag while busy: DROP pulses once, stream unchanged
        Arith_Flag = 1'b1;
        step();
        Arith_Flag = 1'b0;
        Arith_OUT = 16'hCAFE;
        step();
        check("busy_byte0", 32'(tx_if.TX_DATA), 32'hFE);
        SHIFT_Flag = 1'b1;
        SHIFT_OUT = 8'hFF;
        step();
        SHIFT_Flag = 1'b0;
        check("drop_pulse", 32'(DROP), 32'd1);
        check("busy_byte1", 32'(tx_if.TX_DATA), 32'hCA);
        check("busy_res_out", 32'(RES_OUT), 32'hCAFE);
        step();
        check("drop_clear", 32'(DROP), 32'd0);
        check("busy_done", 32'(BUSY), 32'd0);
        check("busy_no_capture", 32'(STATE_DBG), 32'd0);

        // Reset mid-SEND: asynchronous clear
        tx_if.TX_READY = 1'b0;
        Arith_Flag = 1'b1;
        step();
        Arith_Flag = 1'b0;
        Arith_OUT = 16'h1111;
        step();
        check("pre_rst_valid", 32'(tx_if.TX_VALID), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_tx_valid", 32'(tx_if.TX_VALID), 32'd0);
        check("rst_tx_data", 32'(tx_if.TX_DATA), 32'd0);
        check("rst_res_out", 32'(RES_OUT), 32'd0);
        check("rst_res_valid", 32'(RES_VALID), 32'd0);
        check("rst_drop_multi", 32'({DROP, MULTI_ERR}), 32'd0);
        step();
        RST = 1'b1;
        tx_if.TX_READY = 1'b1;
        step();
        check("post_rst_busy", 32'(BUSY), 32'd0);
        check("post_rst_tx_valid", 32'(tx_if.TX_VALID), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
